// File: rtl/moore_zout_counter_pkg.sv
// Shared types and constants for the Zout detection counter and the upstream
// Moore sequence detector whose output it consumes.
package moore_zout_counter_pkg;

    // Report-window FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COUNT  = 2'b01,
        ST_REPORT = 2'b10
    } state_t;

    // Upstream Moore detector states (Zout is high only in DET_FOUND).
    localparam logic [1:0] DET_S0    = 2'b00;
    localparam logic [1:0] DET_S1    = 2'b01;
    localparam logic [1:0] DET_S2    = 2'b10;
    localparam logic [1:0] DET_FOUND = 2'b11;

    // Detections per report window unless overridden.
    localparam int THRESH_DEFAULT = 4;

    // The window counter is always 8 bits, wide enough for THRESH up to 255.
    localparam int WIN_W = 8;

    // Window increment that sticks at the limit instead of wrapping.
    function automatic logic [WIN_W-1:0] win_bump(
        input logic [WIN_W-1:0] win,
        input logic [WIN_W-1:0] limit
    );
        if (win >= limit) begin
            return limit;
        end
        return win + 8'd1;
    endfunction

endpackage

// File: rtl/moore_zout_counter_sat_counter.sv
// Saturating up-counter with a sticky flag that rises on the same edge the
// count reaches all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    logic at_max;
    logic near_max;

    assign at_max   = (q == MAX);
    assign near_max = (q == (MAX - 1'b1));

    // Count register: clear wins, otherwise step until all-ones then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + 1'b1;
        end
    end

    // Sticky saturation flag, set together with the final increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (clr) begin
            sat <= 1'b0;
        end else if (inc && near_max) begin
            sat <= 1'b1;
        end
    end

endmodule

// File: rtl/moore_zout_counter.sv
// Counts rising edges of the upstream Moore detector output and raises a
// report request every THRESH detections.
//
// state  | meaning
// IDLE   | not counting; edges ignored, waits for en
// COUNT  | counting detections into the current window
// REPORT | window full, irq high until ack; detections still counted (miss)
module moore_zout_counter
    import moore_zout_counter_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int THRESH = THRESH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             en,
    input  logic             clr,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             irq,
    output logic             miss
);

    localparam logic [WIN_W-1:0] WIN_LIMIT = 8'(THRESH);

    state_t           state;
    state_t           state_nxt;
    logic             z_prev;
    logic             det;
    logic             counted;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] win_nxt;
    logic [WIN_W-1:0] win_bumped;

    // A long high level on z_in is a single detection.
    assign det        = z_in & ~z_prev;
    assign win_bumped = win_bump(win, WIN_LIMIT);

    // Decide whether this cycle's edge is counted; clr always discards it.
    always_comb begin
        counted = 1'b0;
        case (state)
            ST_COUNT:  counted = det & en & ~clr;
            ST_REPORT: counted = det & ~clr;
            default:   counted = 1'b0;
        endcase
    end

    // Edge history is kept in every state so re-enabling never sees a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_prev <= 1'b0;
        end else begin
            z_prev <= z_in;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = en ? ST_COUNT : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state_nxt = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        state_nxt = ST_IDLE;
                    end else if (counted && (win_bumped == WIN_LIMIT)) begin
                        state_nxt = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (ack) begin
                        state_nxt = en ? ST_COUNT : ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Window next value; an edge arriving with ack opens the new window at 1.
    always_comb begin
        win_nxt = win;
        if (clr) begin
            win_nxt = '0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (counted) begin
                        win_nxt = win_bumped;
                    end
                end
                ST_REPORT: begin
                    if (ack) begin
                        win_nxt = counted ? 8'd1 : 8'd0;
                    end
                end
                default: win_nxt = win;
            endcase
        end
    end

    // Window register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else begin
            win <= win_nxt;
        end
    end

    // Sticky miss flag: a detection landed while a report was outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss <= 1'b0;
        end else if (clr) begin
            miss <= 1'b0;
        end else if ((state == ST_REPORT) && counted) begin
            miss <= 1'b1;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        irq = 1'b0;
        if (state == ST_REPORT) begin
            irq = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (counted),
        .q     (count),
        .sat   (sat)
    );

endmodule

// File: tb/tb_moore_zout_counter.sv
// Bench for moore_zout_counter: directed scenarios plus a random run, all
// compared against a cycle-level reference model of the counting rules.
module tb_moore_zout_counter;

    localparam int TH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       z_in;
    logic       en;
    logic       clr;
    logic       ack;
    logic [7:0] count;
    logic       sat;
    logic       irq;
    logic       miss;
    logic [2:0] count3;
    logic       sat3;
    logic       irq3;
    logic       miss3;

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = CNT_W 8, index 1 = CNT_W 3.
    int m_count [2];
    int m_win   [2];
    int m_state [2];
    bit m_sat   [2];
    bit m_miss  [2];
    bit m_zp;
    int m_max   [2] = '{255, 7};

    always #5 clk = ~clk;

    moore_zout_counter #(.CNT_W(8), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .en(en), .clr(clr), .ack(ack),
        .count(count), .sat(sat), .irq(irq), .miss(miss)
    );

    moore_zout_counter #(.CNT_W(3), .THRESH(TH)) dut3 (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .en(en), .clr(clr), .ack(ack),
        .count(count3), .sat(sat3), .irq(irq3), .miss(miss3)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_win[k] = 0; m_state[k] = 0;
            m_sat[k] = 0;   m_miss[k] = 0;
        end
        m_zp = 0;
    endtask

    // States: 0 idle, 1 counting, 2 report pending.
    task automatic model_step(input bit z, input bit e, input bit c, input bit a);
        bit rise;
        rise = z && !m_zp;
        m_zp = z;
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                m_count[k] = 0; m_win[k] = 0; m_sat[k] = 0; m_miss[k] = 0;
                m_state[k] = e ? 1 : 0;
            end else if (m_state[k] == 0) begin
                if (e) m_state[k] = 1;
            end else if (m_state[k] == 1) begin
                if (!e) begin
                    m_state[k] = 0;
                end else if (rise) begin
                    m_count[k] = (m_count[k] + 1 > m_max[k]) ? m_max[k] : m_count[k] + 1;
                    m_win[k]   = (m_win[k] + 1 > TH) ? TH : m_win[k] + 1;
                    if (m_win[k] == TH) m_state[k] = 2;
                end
            end else begin
                if (rise) begin
                    m_count[k] = (m_count[k] + 1 > m_max[k]) ? m_max[k] : m_count[k] + 1;
                    m_miss[k]  = 1;
                end
                if (a) begin
                    m_win[k]   = rise ? 1 : 0;
                    m_state[k] = e ? 1 : 0;
                end
            end
            if (m_count[k] == m_max[k]) m_sat[k] = 1;
        end
    endtask

    task automatic cycle(input bit z, input bit e, input bit c, input bit a);
        z_in = z; en = e; clr = c; ack = a;
        @(posedge clk);
        model_step(z, e, c, a);
        #1;
    endtask

    task automatic pulse(input bit e);
        cycle(1'b1, e, 1'b0, 1'b0);
        cycle(1'b0, e, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; z_in = 0; en = 0; clr = 0; ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if ({sat, irq, miss} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {sat, irq, miss}); end
        checks++; if (2'(dut.state) !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dut.state); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 0, 0);
        checks++; if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL en_to_count got %0d want 1", dut.state); end
    endtask

    task automatic test_count_three();
        repeat (3) pulse(1'b1);
        checks++; if (count !== 8'd3) begin errors++; $display("FAIL three_count got %0d want 3", count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL three_irq got %b want 0", irq); end
        checks++; if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL three_state got %0d want 1", dut.state); end
    endtask

    task automatic test_report_miss();
        cycle(1, 1, 0, 0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fourth_irq got %b want 1", irq); end
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL fourth_count got %0d want 4", count); end
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0); cycle(0, 1, 0, 0); cycle(1, 1, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
        checks++; if (count !== 8'd6) begin errors++; $display("FAIL report_count got %0d want 6", count); end
        checks++; if (miss !== 1'b1) begin errors++; $display("FAIL report_miss got %b want 1", miss); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL report_irq_hold got %b want 1", irq); end
        checks++; if (dut.win !== 8'd4) begin errors++; $display("FAIL report_win got %0d want 4", dut.win); end
    endtask

    task automatic test_ack_pulse();
        cycle(1, 1, 0, 1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq got %b want 0", irq); end
        checks++; if (dut.win !== 8'd1) begin errors++; $display("FAIL ack_win got %0d want 1", dut.win); end
        checks++; if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL ack_state got %0d want 1", dut.state); end
        checks++; if (count !== 8'd7) begin errors++; $display("FAIL ack_count got %0d want 7", count); end
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        checks++; if (dut.win !== 8'd1) begin errors++; $display("FAIL ack_outside_win got %0d want 1", dut.win); end
    endtask

    task automatic test_long_high();
        repeat (10) cycle(1, 1, 0, 0);
        checks++; if (count !== 8'd8) begin errors++; $display("FAIL long_count got %0d want 8", count); end
        repeat (2) cycle(1, 0, 0, 0);
        checks++; if (2'(dut.state) !== 2'd0) begin errors++; $display("FAIL long_idle got %0d want 0", dut.state); end
        repeat (2) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        checks++; if (count !== 8'd8) begin errors++; $display("FAIL reenable_count got %0d want 8", count); end
        checks++; if (dut.win !== 8'd2) begin errors++; $display("FAIL reenable_win got %0d want 2", dut.win); end
    endtask

    task automatic test_saturation();
        cycle(0, 1, 1, 0);
        checks++; if (count3 !== 3'd0 || count !== 8'd0) begin errors++; $display("FAIL clr_count got %0d/%0d want 0/0", count, count3); end
        repeat (9) pulse(1'b1);
        checks++; if (count3 !== 3'd7) begin errors++; $display("FAIL sat3_count got %0d want 7", count3); end
        checks++; if (sat3 !== 1'b1) begin errors++; $display("FAIL sat3_flag got %b want 1", sat3); end
        checks++; if (count !== 8'd9 || sat !== 1'b0) begin errors++; $display("FAIL wide_count got %0d sat %b want 9 sat 0", count, sat); end
        cycle(1, 1, 1, 0);
        checks++; if (count3 !== 3'd0 || sat3 !== 1'b0) begin errors++; $display("FAIL clr_pulse3 got %0d sat %b want 0 sat 0", count3, sat3); end
        checks++; if (count !== 8'd0 || miss !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL clr_pulse got %0d miss %b irq %b want 0 0 0", count, miss, irq); end
        checks++; if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL clr_state got %0d want 1", dut.state); end
        cycle(0, 1, 0, 0);
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL clr_discard got %0d want 0", count); end
    endtask

    task automatic test_async_reset();
        repeat (4) pulse(1'b1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (irq !== 1'b0 || irq3 !== 1'b0) begin errors++; $display("FAIL async_irq got %b/%b want 0/0", irq, irq3); end
        checks++; if ({count, sat, miss} !== 10'd0 || {count3, sat3, miss3} !== 5'd0) begin errors++; $display("FAIL async_outputs got %0d %b %b want 0 0 0", count, sat, miss); end
        checks++; if (dut.win !== 8'd0 || 2'(dut.state) !== 2'd0) begin errors++; $display("FAIL async_state got win %0d st %0d want 0 0", dut.win, dut.state); end
        #3;
        rst_n = 1'b1;
        cycle(0, 1, 0, 0);
        checks++; if (2'(dut.state) !== 2'd1) begin errors++; $display("FAIL first_edge_en got %0d want 1", dut.state); end
    endtask

    task automatic test_random();
        int  a_count;
        bit  a_sat, a_irq, a_miss;
        int  a_win, a_state;
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 9) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
            for (int k = 0; k < 2; k++) begin
                a_count = (k == 0) ? int'(count) : int'(count3);
                a_sat   = (k == 0) ? sat  : sat3;
                a_irq   = (k == 0) ? irq  : irq3;
                a_miss  = (k == 0) ? miss : miss3;
                a_win   = (k == 0) ? int'(dut.win) : int'(dut3.win);
                a_state = (k == 0) ? int'(dut.state) : int'(dut3.state);
                checks++;
                if (a_count != m_count[k] || a_sat != m_sat[k] || a_irq != (m_state[k] == 2) ||
                    a_miss != m_miss[k] || a_win != m_win[k] || a_state != m_state[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got cnt %0d sat %b irq %b miss %b win %0d st %0d want cnt %0d sat %b irq %b miss %b win %0d st %0d",
                             k, n, a_count, a_sat, a_irq, a_miss, a_win, a_state,
                             m_count[k], m_sat[k], m_state[k] == 2, m_miss[k], m_win[k], m_state[k]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_count_three();
        test_report_miss();
        test_ack_pulse();
        test_long_high();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
